// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the integer datapath.
//   REG_IDX_W : width of a register index (X0..X30, XZR)
//   XZR_IDX   : index that reads as zero and discards writes
//   NUM_GPR   : number of physical general-purpose registers
//   xreg_t    : architectural register value type
package cpu_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;
  localparam int unsigned NUM_GPR = 31;
  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] xreg_t;

endpackage

// File: rtl/regfile_wb_rdport.sv
// Combinational read mux for the integer register file.
// Resolves XZR, optional same-cycle write forwarding, and the stored value.
//   addr     : register index to read
//   wr_en    : write strobe of the current cycle (bypass source)
//   wr_addr  : write index of the current cycle
//   wr_data  : write value of the current cycle
//   regs     : storage array (X0..X30)
//   data     : read value, 0 cycles
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [REG_IDX_W-1:0] addr,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W-1:0]    regs [NUM_GPR],
  output logic [DATA_W-1:0]    data
);

  always_comb begin
    data = '0;
    // Unknown control/address bits force a zero read instead of propagating X.
    if ($isunknown({addr, wr_en, wr_addr})) begin
      data = '0;
    end else if (addr == XZR_IDX) begin
      data = '0;
    end else if (BYPASS && wr_en && (wr_addr == addr)) begin
      // addr != XZR here, so a forwarded write is never to index 31
      data = wr_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// ARMv8 integer register file (X0..X30 + XZR), write-back sink for the
// MemtoReg select.
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   rd_addr1/rd_data1    : read port 1 (Rn), combinational
//   rd_addr2/rd_data2    : read port 2 (Rm/Rt), combinational
//   wr_en/wr_addr/wr_data: write-back port, committed at the clock edge
//   dbg_addr/dbg_data    : debug read, registered (1-cycle latency)
//   wr_count             : saturating count of committed writes
module regfile_wb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rd_addr1,
  input  logic [REG_IDX_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [CNT_W-1:0]     wr_count
);

  logic [DATA_W-1:0] regs [NUM_GPR];
  logic [DATA_W-1:0] dbg_pre;
  logic              commit;

  always_comb begin
    commit = 1'b0;
    if (!$isunknown({wr_en, wr_addr}))
      commit = wr_en && (wr_addr != XZR_IDX);
  end

  regfile_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rd1 (
    .addr    (rd_addr1),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs),
    .data    (rd_data1)
  );

  regfile_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rd2 (
    .addr    (rd_addr2),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs),
    .data    (rd_data2)
  );

  // Debug port follows port-1 rules (bypass, XZR) and is then registered.
  regfile_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rddbg (
    .addr    (dbg_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs),
    .data    (dbg_pre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_GPR; i++)
        regs[i] <= '0;
      dbg_data <= '0;
      wr_count <= '0;
    end else begin
      if (commit) begin
        regs[wr_addr] <= wr_data;
        if (wr_count != '1)
          wr_count <= wr_count + CNT_W'(1);
      end
      dbg_data <= dbg_pre;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: three builds (bypass, no-bypass,
// 4-bit counter) share one stimulus stream and one behavioural model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic [4:0]  dbg_addr = '0;

  logic [63:0] r1a, r2a, dbga;
  logic [31:0] cnta;
  logic [63:0] r1b, r2b, dbgb;
  logic [31:0] cntb;
  logic [63:0] r1c, r2c, dbgc;
  logic [3:0]  cntc;

  always #5 clk = ~clk;

  regfile_wb #(.DATA_W(64), .BYPASS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(r1a), .rd_data2(r2a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbga), .wr_count(cnta)
  );

  regfile_wb #(.DATA_W(64), .BYPASS(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(r1b), .rd_data2(r2b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbgb), .wr_count(cntb)
  );

  regfile_wb #(.DATA_W(64), .BYPASS(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(r1c), .rd_data2(r2c), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbgc), .wr_count(cntc)
  );

  // Architectural model: 32 entries, entry 31 never changes from 0.
  logic [63:0] mregs [32];
  longint unsigned mcount;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // What a read of 'a' must show before the edge, given the write in flight.
  function automatic logic [63:0] mread(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic [63:0] sat(input longint unsigned v, input int w);
    longint unsigned top;
    top = (64'd1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] da);
    logic [63:0] edbg_a, edbg_b;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr1 = a1; rd_addr2 = a2; dbg_addr = da;
    #1;
    chk("rd1_byp",   r1a, mread(a1, 1'b1));
    chk("rd2_byp",   r2a, mread(a2, 1'b1));
    chk("rd1_nobyp", r1b, mread(a1, 1'b0));
    chk("rd2_nobyp", r2b, mread(a2, 1'b0));
    chk("rd1_c4",    r1c, mread(a1, 1'b1));
    chk("rd2_c4",    r2c, mread(a2, 1'b1));
    edbg_a = r ? 64'd0 : mread(da, 1'b1);
    edbg_b = r ? 64'd0 : mread(da, 1'b0);
    @(posedge clk);
    if (r) begin
      foreach (mregs[i]) mregs[i] = '0;
      mcount = 0;
    end else if (we && wa != 5'd31) begin
      mregs[wa] = wd;
      mcount++;
    end
    #1;
    chk("dbg_byp",   dbga, edbg_a);
    chk("dbg_nobyp", dbgb, edbg_b);
    chk("dbg_c4",    dbgc, edbg_a);
    chk("cnt32",     {32'd0, cnta}, sat(mcount, 32));
    chk("cnt4",      {60'd0, cntc}, sat(mcount, 4));
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = '0;
    mcount = 0;

    // Bring every build out of its power-up state before modelling it.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset, then sweep all indices on both ports and the debug port
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));

    // 2: two consecutive writes, then read them back
    cycle(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0);
    cycle(0, 1, 30, 64'h1, 5, 5, 5);
    cycle(0, 0, 0, 0, 5, 30, 30);

    // 3: writes to XZR are dropped, including the same-cycle read
    cycle(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 31);
    cycle(0, 0, 0, 0, 31, 31, 31);

    // 4: forwarding on both ports (bypass build) vs old value (no-bypass build)
    cycle(0, 1, 7, 64'h1234, 0, 0, 0);
    cycle(0, 1, 7, 64'hA5, 7, 7, 7);
    cycle(0, 0, 0, 0, 7, 7, 7);

    // 5: reset wins over a simultaneous write
    cycle(0, 1, 3, 64'h99, 3, 3, 3);
    cycle(1, 1, 3, 64'h55, 3, 3, 3);
    cycle(0, 0, 0, 0, 3, 5, 7);

    // 6: drive the 4-bit counter through its saturation point
    for (int i = 0; i < 18; i++)
      cycle(0, 1, 5'(i % 31), {32'(i), 32'hC0DE_0000}, 5'(i % 31), 5'((i + 1) % 31), 5'(i % 31));

    // Randomized traffic, mostly aimed at a few hot registers to exercise bypass
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2, da;
      logic [63:0] wd;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      da = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wa, wd, a1, a2, da);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
